// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Waits for the data-SRAM response of an issued request, aligns and extends
// load data, buffers the response while WB stalls, and swallows responses
// that belong to instructions killed by a WB flush.
// Optional feature macro: MS_FWD_EN (forward final_result to ID).
// Bus widths: ES_TO_MS_BUS_WD = 173, MS_TO_WS_BUS_WD = 167, MS_TO_DS_BUS_WD = 39.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [172:0] es_to_ms_bus,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [166:0] ms_to_ws_bus,
    input  logic         ws_flush_pipe,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_es_ex,
    output logic [38:0]  ms_to_ds_bus
);

    logic         r_ms_valid;
    logic [172:0] r_bus;
    logic         r_rbuf_valid;
    logic [31:0]  r_rbuf;
    logic [1:0]   r_cancel_cnt;
    logic [1:0]   w_cancel_cnt_d;

    logic [4:0]   w_load_op;
    logic         w_mem_req;
    logic         w_ex;
    logic         w_ertn;
    logic         w_gr_we;
    logic [4:0]   w_dest;
    logic [31:0]  w_alu_result;

    logic         w_data_ok_hit;
    logic         w_ready_go;
    logic         w_ms_wait;
    logic         w_leave;
    logic [31:0]  w_rd;
    logic [31:0]  w_shifted;
    logic [15:0]  w_half;
    logic [31:0]  w_aligned;
    logic [31:0]  w_final_result;
    logic [31:0]  w_fwd_data;

    // Payload field extraction.
    assign w_load_op    = r_bus[172:168];
    assign w_mem_req    = r_bus[167];
    assign w_ex         = r_bus[157];
    assign w_ertn       = r_bus[156];
    assign w_gr_we      = r_bus[69];
    assign w_dest       = r_bus[68:64];
    assign w_alu_result = r_bus[63:32];

    // A response only counts for this instruction once all cancelled ones are drained.
    assign w_data_ok_hit = data_sram_data_ok && (r_cancel_cnt == 2'd0);
    assign w_ready_go    = !w_mem_req || w_data_ok_hit || r_rbuf_valid;
    assign w_ms_wait     = r_ms_valid && w_mem_req && !w_ready_go;
    assign w_leave       = r_ms_valid && w_ready_go && ws_allowin;

    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ws_flush_pipe;
    assign ms_to_es_ex    = r_ms_valid && (w_ex || w_ertn);

    // Valid bit: flush empties the stage ahead of any new entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ws_flush_pipe) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register from EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            r_bus <= es_to_ms_bus;
        end
    end

    // Response buffer: holds load data while WB is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rbuf_valid <= 1'b0;
            r_rbuf       <= 32'd0;
        end else if (ws_flush_pipe || w_leave) begin
            r_rbuf_valid <= 1'b0;
        end else if (w_data_ok_hit && r_ms_valid && w_mem_req && !ws_allowin) begin
            r_rbuf_valid <= 1'b1;
            r_rbuf       <= data_sram_rdata;
        end
    end

    // Cancel counter next state: count outstanding responses of flushed requests.
    always_comb begin
        logic [1:0] inc;
        logic       dec;
        logic [2:0] sum;
        inc = 2'd0;
        if (ws_flush_pipe) begin
            inc = {1'b0, r_ms_valid && w_mem_req && !r_rbuf_valid && !w_data_ok_hit}
                + {1'b0, es_to_ms_valid && es_to_ms_bus[167]};
        end
        dec = data_sram_data_ok && (r_cancel_cnt != 2'd0);
        sum = {1'b0, r_cancel_cnt} + {1'b0, inc} - {2'b00, dec};
        w_cancel_cnt_d = (sum > 3'd3) ? 2'd3 : sum[1:0];
    end

    // Cancel counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cancel_cnt <= 2'd0;
        end else begin
            r_cancel_cnt <= w_cancel_cnt_d;
        end
    end

    // Load data alignment and extension.
    always_comb begin
        w_rd      = r_rbuf_valid ? r_rbuf : data_sram_rdata;
        w_shifted = w_rd >> {w_alu_result[1:0], 3'b000};
        w_half    = w_alu_result[1] ? w_rd[31:16] : w_rd[15:0];
        w_aligned = 32'd0;
        unique case (w_load_op)
            5'b00001: w_aligned = {{24{w_shifted[7]}}, w_shifted[7:0]};
            5'b00010: w_aligned = {24'd0, w_shifted[7:0]};
            5'b00100: w_aligned = {{16{w_half[15]}}, w_half};
            5'b01000: w_aligned = {16'd0, w_half};
            5'b10000: w_aligned = w_rd;
            default:  w_aligned = 32'd0;
        endcase
        w_final_result = (|w_load_op) ? w_aligned : w_alu_result;
    end

`ifdef MS_FWD_EN
    assign w_fwd_data = w_final_result;
`else
    assign w_fwd_data = 32'd0;
`endif

    assign ms_to_ws_bus = {r_bus[166:64], w_final_result, r_bus[31:0]};
    assign ms_to_ds_bus = {r_ms_valid && w_gr_we, w_ms_wait, w_dest, w_fwd_data};

endmodule
